dual_port_sram_be: RTL
======================

Name: dual_port_sram_be

Overview:
- Single-clock true dual-port SRAM. Replaces the dual-clock, full-word-write dual port memory in new datapaths.
- Adds per-byte write enables, a selectable read-during-write mode, and deterministic same-address collision resolution.
- Adds an optional output register stage and a post-reset hardware clear sequencer.
- Sits between packet-buffer/descriptor logic and its consumers, where both ports share one clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 10, address width.
- MEM_DEPTH, 1<<ADDR_WIDTH, number of words. Must be ≤ 2^ADDR_WIDTH.
- WRITE_FIRST, 1, read-during-write mode. 1 = a read of an address written in the same cycle returns the new merged data. 0 = it returns the old data.
- OUT_REG, 0, output register stage. 1 = extra output register, read latency 2. 0 = read latency 1.
- CLEAR_ON_RESET, 1, post-reset clear. 1 = zero every word after reset. 0 = memory contents undefined, ready one cycle after reset.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ready  out  1  high when requests are accepted. Low during reset and clear.
- en_a  in  1  port A request.
- we_a  in  1  port A write (else read).
- be_a  in  DATA_WIDTH/8  port A byte enables. bit i covers din_a[8i+7:8i].
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A read data.
- dout_valid_a  out  1  dout_a holds the response to an accepted read.
- en_b, we_b, be_b, addr_b, din_b, dout_b, dout_valid_b: identical to port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address with overlapping byte enables.

Behaviour:
- Reset (asynchronous):
  - dout_a, dout_b, dout_valid_a, dout_valid_b, collision and ready go to 0 immediately.
  - Clear state is forced to CLR with the clear pointer at 0.
- Clear state machine, states CLR / RUN:
  - CLR: on each clock after rst deasserts, writes 0 to mem[ptr] and increments ptr.
  - At ptr == MEM_DEPTH-1, the last word is written and the state goes to RUN on that edge. ready rises the following cycle, so the clear takes MEM_DEPTH cycles.
  - With CLEAR_ON_RESET=0 the block enters RUN directly and ready is 1 one cycle after rst deasserts.
  - rst asserted mid-clear restarts the clear from address 0.
- Request acceptance:
  - A request is accepted when en_x && ready in a cycle.
  - Requests while ready=0 are ignored: no write, no dout_valid.
- Writes:
  - Only bytes with be set are updated; other bytes keep their contents.
  - we with be all zero is a no-op write that still counts as accepted, and produces no dout_valid.
- Reads:
  - dout_valid_x is asserted exactly 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after an accepted read. It is deasserted otherwise.
  - dout_x holds its last value when valid is low.
- Back-to-back throughput: one request per port per cycle, no bubbles.
- Read-during-write (same or opposite port, same address, same cycle):
  - WRITE_FIRST=1: the reader sees the old word with the written bytes replaced.
  - WRITE_FIRST=0: the reader sees the old word.
  - A same-port write returns no read; dout_valid is only for reads.
- Write/write collision (both ports write the same address in the same cycle):
  - Byte lanes enabled by both ports take port A's data.
  - Lanes enabled by only one port take that port's data.
  - collision pulses high for 1 cycle, the cycle after, only if be_a & be_b != 0.
  - Under WRITE_FIRST=1, a same-cycle read by a third party is not possible: there are two ports only.
- Address out of range (addr ≥ MEM_DEPTH when MEM_DEPTH < 2^ADDR_WIDTH):
  - Writes are dropped.
  - Reads return 0 with dout_valid asserted normally.
- Both ports reading the same address: both get identical data, with no collision flagged.

Test Plan:
- Reset/clear: MEM_DEPTH=16, rst pulse, then read all 16 addresses via port A after ready.
  - ready rises 17 cycles after rst falls.
  - Every read returns 0x00000000.
  - Reads issued before ready give no dout_valid.
- Byte-enable merge: write A addr 5 = 0xAABBCCDD be=1111, then write B addr 5 = 0x11223344 be=0101. A read addr 5 returns 0xAA22CC44, with latency 1 (OUT_REG=0) and 2 (OUT_REG=1).
- Read-during-write: mem[7]=0x0; same cycle A writes 0xDEADBEEF be=1111 and B reads 7.
  - WRITE_FIRST=1: dout_b = 0xDEADBEEF.
  - WRITE_FIRST=0: dout_b = 0x0.
  - A subsequent read returns 0xDEADBEEF in both modes.
- Write collision: same cycle, A writes addr 3 = 0x11111111 be=0011 and B writes addr 3 = 0x22222222 be=0110.
  - Read returns 0x00221111 (from cleared memory).
  - collision pulses 1 cycle.
  - Repeating with be_b=1100 gives no collision pulse and reads 0x22221111.
- Reset mid-clear: assert rst at clear cycle 8 of 16, release. ready rises 17 cycles after the second release, and all words read 0.
- Streaming: 64 consecutive cycles of A writes (addr i, data i*3) while B reads addr i-1.
  - WRITE_FIRST=1: every dout_b equals (i-1)*3.
  - dout_valid_b is continuous, with no gaps.

Source files
------------

// File: rtl/dual_port_sram_be_if.sv
// Request/response bundle for dual_port_sram_be: two symmetric byte-enabled
// ports plus the shared ready and collision flags.
interface dual_port_sram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  ready;
  logic                  collision;

  logic                  en_a, we_a, dout_valid_a;
  logic [NB-1:0]         be_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a, dout_a;

  logic                  en_b, we_b, dout_valid_b;
  logic [NB-1:0]         be_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b, dout_b;

  modport master (
    input  ready, collision,
    output en_a, we_a, be_a, addr_a, din_a,
    input  dout_a, dout_valid_a,
    output en_b, we_b, be_b, addr_b, din_b,
    input  dout_b, dout_valid_b
  );

  modport slave (
    output ready, collision,
    input  en_a, we_a, be_a, addr_a, din_a,
    output dout_a, dout_valid_a,
    input  en_b, we_b, be_b, addr_b, din_b,
    output dout_b, dout_valid_b
  );
endinterface

// File: rtl/dual_port_sram_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write,
// port-A-priority write collisions, optional output register and post-reset clear.
module dual_port_sram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_DEPTH      = 1 << ADDR_WIDTH,
  parameter bit WRITE_FIRST    = 1'b1,
  parameter bit OUT_REG        = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  dual_port_sram_be_if.slave   bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [IW-1:0]       LAST    = IW'(MEM_DEPTH - 1);

  localparam logic [0:0] CLR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;

  logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic          rdy;

  logic          ok_a, ok_b, same;
  logic          rd_a, rd_b, wr_a, wr_b;
  logic [IW-1:0] ia, ib;
  logic [DATA_WIDTH-1:0] old_a, old_b, rdata_a, rdata_b;

  // Addresses past MEM_DEPTH never touch the array: writes drop, reads give 0.
  assign ok_a = {1'b0, bus.addr_a} < DEPTH_W;
  assign ok_b = {1'b0, bus.addr_b} < DEPTH_W;
  assign ia   = bus.addr_a[IW-1:0];
  assign ib   = bus.addr_b[IW-1:0];
  assign same = (bus.addr_a == bus.addr_b);

  assign rd_a = bus.en_a && rdy && !bus.we_a;
  assign rd_b = bus.en_b && rdy && !bus.we_b;
  assign wr_a = bus.en_a && rdy &&  bus.we_a && ok_a;
  assign wr_b = bus.en_b && rdy &&  bus.we_b && ok_b;

  assign old_a = ok_a ? mem[ia] : '0;
  assign old_b = ok_b ? mem[ib] : '0;

  // Write-first bypass: only the opposite port can write while this port reads.
  always_comb begin
    rdata_a = old_a;
    rdata_b = old_b;
    for (int i = 0; i < NB; i++) begin
      if (WRITE_FIRST && wr_b && same && bus.be_b[i]) rdata_a[8*i +: 8] = bus.din_b[8*i +: 8];
      if (WRITE_FIRST && wr_a && same && bus.be_a[i]) rdata_b[8*i +: 8] = bus.din_a[8*i +: 8];
    end
  end

  // Lanes enabled by both ports on the same word keep port A's byte.
  always_ff @(posedge clk) begin
    if (state == CLR) begin
      mem[ptr] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && bus.be_b[i] && !(wr_a && same && bus.be_a[i]))
          mem[ib][8*i +: 8] <= bus.din_b[8*i +: 8];
        if (wr_a && bus.be_a[i])
          mem[ia][8*i +: 8] <= bus.din_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLR : RUN;
      ptr   <= '0;
      rdy   <= 1'b0;
    end else begin
      rdy <= (state == RUN);
      if (state == CLR) begin
        ptr <= ptr + 1'b1;
        if (ptr == LAST) state <= RUN;
      end
    end
  end

  logic [1:0]            vld_a_pipe, vld_b_pipe;
  logic [DATA_WIDTH-1:0] q1_a, q1_b, q2_a, q2_b;
  logic                  col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_pipe <= '0;
      vld_b_pipe <= '0;
      q1_a       <= '0;
      q1_b       <= '0;
      q2_a       <= '0;
      q2_b       <= '0;
      col        <= 1'b0;
    end else begin
      vld_a_pipe <= {vld_a_pipe[0], rd_a};
      vld_b_pipe <= {vld_b_pipe[0], rd_b};
      if (rd_a)          q1_a <= rdata_a;
      if (rd_b)          q1_b <= rdata_b;
      if (vld_a_pipe[0]) q2_a <= q1_a;
      if (vld_b_pipe[0]) q2_b <= q1_b;
      col <= wr_a && wr_b && same && |(bus.be_a & bus.be_b);
    end
  end

  assign bus.ready        = rdy;
  assign bus.collision    = col;
  assign bus.dout_a       = OUT_REG ? q2_a : q1_a;
  assign bus.dout_b       = OUT_REG ? q2_b : q1_b;
  assign bus.dout_valid_a = vld_a_pipe[OUT_REG];
  assign bus.dout_valid_b = vld_b_pipe[OUT_REG];
endmodule
